// File: rtl/load_store_unit.sv
// Load/store initiator between the core pipeline and data memory.
// Holds one request at a time. Returns extended load data, a store completion, or an error.
//
// state      | meaning
// IDLE       | RequestReady high; waiting for a core request
// READ_WAIT  | ReadEnable high; waiting for ReadReady or timeout
// WRITE_WAIT | WriteEnable high; waiting for WriteReady or timeout
// RESPOND    | one-cycle ResponseValid pulse, then back to IDLE
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RequestValid,
    output logic        RequestReady,
    input  logic        RequestWrite,
    input  logic        RequestWidth,
    input  logic        RequestSigned,
    input  logic [15:0] RequestAddress,
    input  logic [15:0] RequestData,
    output logic        ResponseValid,
    output logic [15:0] ResponseData,
    output logic        ResponseError,
    output logic        ReadEnable,
    output logic        WriteEnable,
    output logic        DataWidth,
    output logic [15:0] DataAddress,
    output logic [15:0] MemoryDataOut,
    input  logic [15:0] MemoryDataIn,
    input  logic        ReadReady,
    input  logic        WriteReady
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RESPOND    = 2'd3
    } stateType;

    // The wait ends when the counter reaches this value with no Ready seen,
    // so the enable is high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    stateType    state, stateNext;
    logic [15:0] waitCount, waitCountNext;
    logic        loadSigned, loadSignedNext;

    logic        requestReadyNext;
    logic        responseValidNext;
    logic [15:0] responseDataNext;
    logic        responseErrorNext;
    logic        readEnableNext;
    logic        writeEnableNext;
    logic        dataWidthNext;
    logic [15:0] dataAddressNext;
    logic [15:0] memoryDataOutNext;

    logic [15:0] loadResult;
    logic        timedOut;

    assign timedOut = (waitCount == LAST_COUNT);

    always_comb begin
        loadResult = MemoryDataIn;
        if (!DataWidth) begin
            if (loadSigned) begin
                loadResult = {{8{MemoryDataIn[7]}}, MemoryDataIn[7:0]};
            end else begin
                loadResult = {8'h00, MemoryDataIn[7:0]};
            end
        end
    end

    always_comb begin
        stateNext         = state;
        waitCountNext     = waitCount;
        loadSignedNext    = loadSigned;
        requestReadyNext  = 1'b0;
        responseValidNext = 1'b0;
        responseDataNext  = 16'h0000;
        responseErrorNext = 1'b0;
        readEnableNext    = ReadEnable;
        writeEnableNext   = WriteEnable;
        dataWidthNext     = DataWidth;
        dataAddressNext   = DataAddress;
        memoryDataOutNext = MemoryDataOut;

        case (state)
            IDLE: begin
                requestReadyNext = 1'b1;
                if (RequestValid && RequestReady) begin
                    requestReadyNext = 1'b0;
                    if (RequestWidth && RequestAddress[0]) begin
                        // Misaligned word: fail without touching memory.
                        stateNext         = RESPOND;
                        responseValidNext = 1'b1;
                        responseErrorNext = 1'b1;
                    end else begin
                        waitCountNext     = 16'h0000;
                        loadSignedNext    = RequestSigned;
                        dataWidthNext     = RequestWidth;
                        dataAddressNext   = RequestAddress;
                        memoryDataOutNext = RequestWidth ? RequestData
                                                         : {8'h00, RequestData[7:0]};
                        if (RequestWrite) begin
                            writeEnableNext = 1'b1;
                            stateNext       = WRITE_WAIT;
                        end else begin
                            readEnableNext = 1'b1;
                            stateNext      = READ_WAIT;
                        end
                    end
                end
            end

            READ_WAIT: begin
                if (ReadReady) begin
                    readEnableNext    = 1'b0;
                    responseValidNext = 1'b1;
                    responseDataNext  = loadResult;
                    stateNext         = RESPOND;
                end else if (timedOut) begin
                    readEnableNext    = 1'b0;
                    responseValidNext = 1'b1;
                    responseErrorNext = 1'b1;
                    stateNext         = RESPOND;
                end else begin
                    waitCountNext = waitCount + 16'd1;
                end
            end

            WRITE_WAIT: begin
                if (WriteReady) begin
                    writeEnableNext   = 1'b0;
                    responseValidNext = 1'b1;
                    stateNext         = RESPOND;
                end else if (timedOut) begin
                    writeEnableNext   = 1'b0;
                    responseValidNext = 1'b1;
                    responseErrorNext = 1'b1;
                    stateNext         = RESPOND;
                end else begin
                    waitCountNext = waitCount + 16'd1;
                end
            end

            RESPOND: begin
                requestReadyNext = 1'b1;
                stateNext        = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            waitCount     <= 16'h0000;
            loadSigned    <= 1'b0;
            RequestReady  <= 1'b1;
            ResponseValid <= 1'b0;
            ResponseData  <= 16'h0000;
            ResponseError <= 1'b0;
            ReadEnable    <= 1'b0;
            WriteEnable   <= 1'b0;
            DataWidth     <= 1'b0;
            DataAddress   <= 16'h0000;
            MemoryDataOut <= 16'h0000;
        end else begin
            state         <= stateNext;
            waitCount     <= waitCountNext;
            loadSigned    <= loadSignedNext;
            RequestReady  <= requestReadyNext;
            ResponseValid <= responseValidNext;
            ResponseData  <= responseDataNext;
            ResponseError <= responseErrorNext;
            ReadEnable    <= readEnableNext;
            WriteEnable   <= writeEnableNext;
            DataWidth     <= dataWidthNext;
            DataAddress   <= dataAddressNext;
            MemoryDataOut <= memoryDataOutNext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: directed cases plus random requests
// against a simple memory responder, with a separate response monitor.
module tb_load_store_unit;

    localparam int TIMEOUT = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        RequestValid = 1'b0;
    logic        RequestReady;
    logic        RequestWrite = 1'b0;
    logic        RequestWidth = 1'b0;
    logic        RequestSigned = 1'b0;
    logic [15:0] RequestAddress = 16'h0000;
    logic [15:0] RequestData = 16'h0000;
    logic        ResponseValid;
    logic [15:0] ResponseData;
    logic        ResponseError;
    logic        ReadEnable;
    logic        WriteEnable;
    logic        DataWidth;
    logic [15:0] DataAddress;
    logic [15:0] MemoryDataOut;
    logic [15:0] MemoryDataIn = 16'h0000;
    logic        ReadReady = 1'b0;
    logic        WriteReady = 1'b0;

    always #5 Clock = ~Clock;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset),
        .RequestValid(RequestValid), .RequestReady(RequestReady),
        .RequestWrite(RequestWrite), .RequestWidth(RequestWidth),
        .RequestSigned(RequestSigned), .RequestAddress(RequestAddress),
        .RequestData(RequestData),
        .ResponseValid(ResponseValid), .ResponseData(ResponseData),
        .ResponseError(ResponseError),
        .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
        .DataWidth(DataWidth), .DataAddress(DataAddress),
        .MemoryDataOut(MemoryDataOut), .MemoryDataIn(MemoryDataIn),
        .ReadReady(ReadReady), .WriteReady(WriteReady)
    );

    typedef struct {
        logic [15:0] data;
        logic        error;
    } respType;

    respType expectQ[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Reference: what the core should get back for a request, given the
    // enable cycle (1-based) in which memory answers.
    function automatic respType modelResponse(input logic write, input logic width,
                                              input logic sgn, input logic [15:0] addr,
                                              input logic [15:0] memData, input int readyAt);
        respType r;
        int b;
        r.data  = 16'h0000;
        r.error = 1'b0;
        b = int'(memData) % 256;
        if (width && (int'(addr) % 2 == 1)) begin
            r.error = 1'b1;
        end else if (readyAt > TIMEOUT) begin
            r.error = 1'b1;
        end else if (!write) begin
            if (width) r.data = memData;
            else if (sgn && b >= 128) r.data = 16'(b + 65280);
            else r.data = 16'(b);
        end
        return r;
    endfunction

    initial begin
        forever begin
            respType e;
            @(negedge Clock);
            if (!Reset && ResponseValid) begin
                if (expectQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpectedResponse: got data 0x%0h error %0b, expected no response",
                             ResponseData, ResponseError);
                end else begin
                    e = expectQ.pop_front();
                    check("responseData", 32'(ResponseData), 32'(e.data));
                    check("responseError", 32'(ResponseError), 32'(e.error));
                end
            end
        end
    end

    task automatic waitIdle();
        for (int i = 0; i < 20 && !RequestReady; i++) begin
            @(posedge Clock);
            #1;
        end
        check("requestReadyIdle", 32'(RequestReady), 32'd1);
    endtask

    task automatic runTxn(input logic write, input logic width, input logic sgn,
                          input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] memData, input int readyAt, input logic stray);
        int enCycles = 0;
        int validCycles = 0;
        int validAt = 0;
        int expEn;
        logic stableOk = 1'b1;
        logic en, other;
        logic [15:0] expOut;
        expOut = width ? data : (data & 16'h00FF);
        waitIdle();
        RequestValid   = 1'b1;
        RequestWrite   = write;
        RequestWidth   = width;
        RequestSigned  = sgn;
        RequestAddress = addr;
        RequestData    = data;
        expectQ.push_back(modelResponse(write, width, sgn, addr, memData, readyAt));
        @(posedge Clock);
        #1;
        RequestValid   = 1'b0;
        RequestAddress = 16'($urandom);
        RequestData    = 16'($urandom);
        check("requestReadyBusy", 32'(RequestReady), 32'd0);
        for (int c = 1; c <= 11; c++) begin
            ReadReady    = write ? stray : (c == readyAt);
            WriteReady   = write ? (c == readyAt) : stray;
            MemoryDataIn = (c == readyAt) ? memData : 16'($urandom);
            en    = write ? WriteEnable : ReadEnable;
            other = write ? ReadEnable : WriteEnable;
            if (en) begin
                enCycles++;
                if (DataAddress !== addr || DataWidth !== width || MemoryDataOut !== expOut)
                    stableOk = 1'b0;
            end
            if (other) stableOk = 1'b0;
            if (ResponseValid) begin
                validCycles++;
                validAt = c;
            end
            @(posedge Clock);
            #1;
        end
        ReadReady  = 1'b0;
        WriteReady = 1'b0;
        if (width && addr[0]) expEn = 0;
        else if (readyAt <= TIMEOUT) expEn = readyAt;
        else expEn = TIMEOUT;
        check("enableCycles", 32'(enCycles), 32'(expEn));
        check("responsePulses", 32'(validCycles), 32'd1);
        check("responseCycle", 32'(validAt), 32'(expEn + 1));
        check("busStable", 32'(stableOk), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("resetReadEnable", 32'(ReadEnable), 32'd0);
        check("resetWriteEnable", 32'(WriteEnable), 32'd0);
        check("resetResponseValid", 32'(ResponseValid), 32'd0);
        check("resetResponseError", 32'(ResponseError), 32'd0);
        check("resetResponseData", 32'(ResponseData), 32'd0);
        check("resetDataAddress", 32'(DataAddress), 32'd0);
        check("resetMemoryDataOut", 32'(MemoryDataOut), 32'd0);
        check("resetDataWidth", 32'(DataWidth), 32'd0);
        check("resetRequestReady", 32'(RequestReady), 32'd1);
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        runTxn(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0080, 5, 1'b0);
        runTxn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0080, 5, 1'b0);
        runTxn(1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1, 1'b0);
        runTxn(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 16'h1234, 2, 1'b0);
        runTxn(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555, 99, 1'b1);
        runTxn(1'b1, 1'b0, 1'b0, 16'h0041, 16'h12AB, 16'h0000, 3, 1'b1);
        runTxn(1'b0, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 16'hA5C3, 8, 1'b0);
        runTxn(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h00C7, 16'h0000, 2, 1'b0);
        runTxn(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h7777, 16'h0000, 2, 1'b0);
        runTxn(1'b1, 1'b1, 1'b0, 16'h0100, 16'h4321, 16'h0000, 9, 1'b0);

        // Abandon a load mid-wait with Reset; no response may follow.
        waitIdle();
        RequestValid   = 1'b1;
        RequestWrite   = 1'b0;
        RequestWidth   = 1'b1;
        RequestAddress = 16'h0200;
        @(posedge Clock);
        #1;
        RequestValid = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("readEnableBeforeReset", 32'(ReadEnable), 32'd1);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("readEnableAfterReset", 32'(ReadEnable), 32'd0);
        check("responseValidAfterReset", 32'(ResponseValid), 32'd0);
        Reset = 1'b0;
        check("requestReadyAfterReset", 32'(RequestReady), 32'd1);
        repeat (3) @(posedge Clock);
        #1;

        for (int n = 0; n < 40; n++) begin
            runTxn(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), int'($urandom_range(1, 10)),
                   1'($urandom));
        end

        repeat (3) @(posedge Clock);
        #1;
        check("scoreboardEmpty", 32'(expectQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
